mpu_regfile: RTL and testbench

MPU_REGFILE -- requirements
Module: mpu_regfile

---
 rtl/mpu_regfile.sv | 161 ++++++++++++++++
 tb/tb_mpu_regfile.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_regfile.sv
// Multi-ported register file with lane-masked writes through a one-deep write stage,
// read forwarding, a per-register busy scoreboard and a zeroing sweep after reset/clear.
module mpu_regfile #(
   parameter int NB_REG = 32,
   parameter int DATA_W = 64,
   parameter int IDX_W  = 5
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   output logic              ready,
   input  logic [IDX_W-1:0]  r_idx0,
   input  logic [IDX_W-1:0]  r_idx1,
   input  logic [IDX_W-1:0]  r_idx2,
   output logic [DATA_W-1:0] r_data0,
   output logic [DATA_W-1:0] r_data1,
   output logic [DATA_W-1:0] r_data2,
   output logic              r_busy0,
   output logic              r_busy1,
   output logic              r_busy2,
   input  logic              we,
   input  logic [IDX_W-1:0]  w_idx,
   input  logic [DATA_W-1:0] w_data,
   input  logic [3:0]        w_sel,
   input  logic [2:0]        w_size,
   output logic              w_err,
   input  logic              rsv,
   input  logic [IDX_W-1:0]  rsv_idx,
   input  logic              clr_req
);

   // state    | meaning
   // ST_CLEAR | sweeping zeros into regs[cnt], writes rejected, ready low
   // ST_IDLE  | normal operation, writes accepted, ready high
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              w_err_q, w_err_d;
   logic [NB_REG-1:0] busy_q, busy_d;
   logic [DATA_W-1:0] regs_q [NB_REG];

   logic [31:0]       lane_w, lane_lo, lane_hi;
   logic [DATA_W-1:0] w_mask;
   logic              w_bad, w_acc, clr_go;
   logic [DATA_W-1:0] commit_val;

   logic [IDX_W-1:0]  rd_idx  [3];
   logic [DATA_W-1:0] rd_data [3];
   logic              rd_busy [3];

   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return 32'(idx) < 32'(NB_REG);
   endfunction

   assign ready  = (state_q == ST_IDLE);
   assign w_err  = w_err_q;
   assign clr_go = ready && clr_req;

   always_comb begin
      lane_w  = 32'd8 << w_size;
      lane_lo = 32'(w_sel) * lane_w;
      lane_hi = lane_lo + lane_w;
      w_bad   = (lane_w > 32'(DATA_W)) || (lane_hi > 32'(DATA_W)) || !idx_ok(w_idx);
      w_mask  = '0;
      for (int b = 0; b < DATA_W; b++) begin
         w_mask[b] = (32'(b) >= lane_lo) && (32'(b) < lane_hi);
      end
   end

   assign w_acc      = we && ready && !w_bad;
   assign commit_val = (regs_q[idx_q] & ~mask_q) | (data_q & mask_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(NB_REG - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else if (clr_req) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end
   end

   always_comb begin
      valid_d = w_acc;
      idx_d   = w_acc ? w_idx  : idx_q;
      mask_d  = w_acc ? w_mask : mask_q;
      data_d  = w_acc ? w_data : data_q;
      w_err_d = we && (!ready || w_bad);
   end

   // A reservation landing on the same edge as a commit to that index keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (valid_q) busy_d[idx_q] = 1'b0;
      if (ready && rsv && idx_ok(rsv_idx)) busy_d[rsv_idx] = 1'b1;
      if (clr_go) busy_d = '0;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         w_err_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         w_err_q <= w_err_d;
         busy_q  <= busy_d;
      end
   end

   // The sweep write is ordered last so it overrides a commit to the same slot.
   always_ff @(posedge sys_clk) begin
      if (valid_q) regs_q[idx_q] <= commit_val;
      if (state_q == ST_CLEAR) regs_q[cnt_q] <= '0;
   end

   assign rd_idx[0] = r_idx0;
   assign rd_idx[1] = r_idx1;
   assign rd_idx[2] = r_idx2;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         rd_data[k] = '0;
         rd_busy[k] = 1'b0;
         if (idx_ok(rd_idx[k])) begin
            rd_busy[k] = busy_q[rd_idx[k]];
            if (ready) begin
               rd_data[k] = (valid_q && rd_idx[k] == idx_q) ? commit_val : regs_q[rd_idx[k]];
            end
         end
      end
   end

   assign r_data0 = rd_data[0];
   assign r_data1 = rd_data[1];
   assign r_data2 = rd_data[2];
   assign r_busy0 = rd_busy[0];
   assign r_busy1 = rd_busy[1];
   assign r_busy2 = rd_busy[2];

endmodule

// File: tb/tb_mpu_regfile.sv
// Bench for mpu_regfile: directed vector table, random traffic against a value-level model,
// and hand sequences for the sweep, clear request and asynchronous reset.
module tb_mpu_regfile;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        ready;
   logic [4:0]  r_idx0, r_idx1, r_idx2;
   logic [63:0] r_data0, r_data1, r_data2;
   logic        r_busy0, r_busy1, r_busy2;
   logic        we;
   logic [4:0]  w_idx;
   logic [63:0] w_data;
   logic [3:0]  w_sel;
   logic [2:0]  w_size;
   logic        w_err;
   logic        rsv;
   logic [4:0]  rsv_idx;
   logic        clr_req;

   int n_cmp  = 0;
   int n_fail = 0;

   mpu_regfile #(.NB_REG(32), .DATA_W(64), .IDX_W(5)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ready(ready),
      .r_idx0(r_idx0), .r_idx1(r_idx1), .r_idx2(r_idx2),
      .r_data0(r_data0), .r_data1(r_data1), .r_data2(r_data2),
      .r_busy0(r_busy0), .r_busy1(r_busy1), .r_busy2(r_busy2),
      .we(we), .w_idx(w_idx), .w_data(w_data), .w_sel(w_sel), .w_size(w_size),
      .w_err(w_err), .rsv(rsv), .rsv_idx(rsv_idx), .clr_req(clr_req)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [4:0]  idx;
      logic [3:0]  sel;
      logic [2:0]  size;
      logic [63:0] data;
      logic        rsv;
      logic [4:0]  rsv_idx;
      logic [4:0]  ridx;
      logic [63:0] exp_data;
      logic        exp_err;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input bit we_v, input int idx, input int sel, input int size,
                               input logic [63:0] data, input bit rsv_v, input int ridx_r,
                               input int ridx, input logic [63:0] exp_data, input bit err,
                               input bit busy);
      vec_t v;
      v.we = we_v; v.idx = 5'(idx); v.sel = 4'(sel); v.size = 3'(size); v.data = data;
      v.rsv = rsv_v; v.rsv_idx = 5'(ridx_r); v.ridx = 5'(ridx);
      v.exp_data = exp_data; v.exp_err = err; v.exp_busy = busy;
      return v;
   endfunction

   // value-level model: an accepted write is visible right away; busy clears one edge later
   logic [63:0] m_regs [32];
   logic        m_busy [32];
   bit          m_pend;
   int          m_pidx;
   logic        m_err;
   bit          model_on;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_pend = 0; m_pidx = 0; m_err = 1'b0;
   endtask

   task automatic model_edge();
      int L, lo;
      logic bad;
      logic [127:0] full;
      logic [63:0] mask;
      L   = 8 << w_size;
      lo  = int'(w_sel) * L;
      bad = (L > 64) || (lo + L > 64);
      m_err = we && bad;
      if (m_pend) m_busy[m_pidx] = 1'b0;
      m_pend = 0;
      if (we && !bad) begin
         full = ((128'd1 << L) - 128'd1) << lo;
         mask = full[63:0];
         m_regs[w_idx] = (m_regs[w_idx] & ~mask) | (w_data & mask);
         m_pend = 1;
         m_pidx = int'(w_idx);
      end
      if (rsv) m_busy[rsv_idx] = 1'b1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 64'(act), 64'(exp));
   endtask

   task automatic idle_inputs();
      we = 1'b0; w_idx = '0; w_data = '0; w_sel = '0; w_size = '0;
      rsv = 1'b0; rsv_idx = '0; clr_req = 1'b0;
   endtask

   task automatic step();
      @(posedge sys_clk);
      if (model_on) model_edge();
      #1;
   endtask

   task automatic count_to_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      idle_inputs();
      for (int i = 0; i < 32; i++) begin
         r_idx0 = 5'(i);
         step();
         chk({tag, "_data"}, r_data0, 64'd0);
         chk1({tag, "_busy"}, r_busy0, 1'b0);
      end
   endtask

   task automatic check_model();
      chk("rnd_data0", r_data0, m_regs[r_idx0]);
      chk("rnd_data1", r_data1, m_regs[r_idx1]);
      chk("rnd_data2", r_data2, m_regs[r_idx2]);
      chk1("rnd_busy0", r_busy0, m_busy[r_idx0]);
      chk1("rnd_busy1", r_busy1, m_busy[r_idx1]);
      chk1("rnd_busy2", r_busy2, m_busy[r_idx2]);
      chk1("rnd_err", w_err, m_err);
      chk1("rnd_ready", ready, 1'b1);
   endtask

   initial begin
      int n;
      model_on = 0;
      model_reset();
      idle_inputs();
      r_idx0 = '0; r_idx1 = '0; r_idx2 = '0;
      sys_rst_n = 1'b0;

      vecs[0]  = mk(1, 3, 0, 3, 64'h1122334455667788, 0, 0, 3, 64'h1122334455667788, 0, 0);
      vecs[1]  = mk(1, 3, 7, 0, 64'hAA00000000000000, 0, 0, 3, 64'hAA22334455667788, 0, 0);
      vecs[2]  = mk(0, 0, 0, 0, 64'h0,                0, 0, 3, 64'hAA22334455667788, 0, 0);
      vecs[3]  = mk(1, 3, 2, 2, 64'hFFFFFFFFFFFFFFFF, 0, 0, 3, 64'hAA22334455667788, 1, 0);
      vecs[4]  = mk(0, 0, 0, 0, 64'h0,                0, 0, 3, 64'hAA22334455667788, 0, 0);
      vecs[5]  = mk(1, 5, 0, 3, 64'h0000000000000055, 0, 0, 5, 64'h0000000000000055, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 64'h0,                1, 5, 5, 64'h0000000000000055, 0, 1);
      vecs[7]  = mk(1, 5, 1, 1, 64'h00000000BEEF0000, 0, 0, 5, 64'h00000000BEEF0055, 0, 1);
      vecs[8]  = mk(0, 0, 0, 0, 64'h0,                0, 0, 5, 64'h00000000BEEF0055, 0, 0);
      vecs[9]  = mk(1, 9, 3, 1, 64'h1234000000000000, 0, 0, 9, 64'h1234000000000000, 0, 0);
      vecs[10] = mk(1, 9, 0, 4, 64'hFFFFFFFFFFFFFFFF, 0, 0, 9, 64'h1234000000000000, 1, 0);
      vecs[11] = mk(1, 9, 1, 2, 64'hCAFEBABE00000000, 0, 0, 9, 64'hCAFEBABE00000000, 0, 0);
      vecs[12] = mk(0, 0, 0, 0, 64'h0,                1, 9, 9, 64'hCAFEBABE00000000, 0, 1);
      vecs[13] = mk(0, 0, 0, 0, 64'h0,                0, 0, 9, 64'hCAFEBABE00000000, 0, 1);

      // reset state and first sweep
      #3;
      chk1("rst_ready", ready, 1'b0);
      chk1("rst_err", w_err, 1'b0);
      chk("rst_data0", r_data0, 64'd0);
      #19 sys_rst_n = 1'b1;
      count_to_ready(n);
      chk("sweep_len", 64'(n), 64'd32);
      check_all_zero("init");

      // directed vector table
      model_reset();
      model_on = 1;
      for (int i = 0; i < 14; i++) begin
         we = vecs[i].we; w_idx = vecs[i].idx; w_sel = vecs[i].sel; w_size = vecs[i].size;
         w_data = vecs[i].data; rsv = vecs[i].rsv; rsv_idx = vecs[i].rsv_idx;
         r_idx0 = vecs[i].ridx;
         step();
         chk($sformatf("vec%0d_data", i), r_data0, vecs[i].exp_data);
         chk1($sformatf("vec%0d_err", i), w_err, vecs[i].exp_err);
         chk1($sformatf("vec%0d_busy", i), r_busy0, vecs[i].exp_busy);
      end

      // random traffic, writes concentrated on a few registers to hit back-to-back merges
      for (int c = 0; c < 400; c++) begin
         we      = ($urandom_range(0, 3) != 0);
         w_idx   = 5'($urandom_range(0, 7));
         w_size  = 3'($urandom_range(0, 4));
         w_sel   = 4'($urandom_range(0, 7));
         w_data  = {$urandom, $urandom};
         rsv     = ($urandom_range(0, 3) == 0);
         rsv_idx = 5'($urandom_range(0, 7));
         r_idx0  = 5'($urandom_range(0, 7));
         r_idx1  = 5'($urandom_range(0, 31));
         r_idx2  = 5'($urandom_range(0, 7));
         step();
         check_model();
      end

      // clear request while a write to reg7 sits in the write stage
      idle_inputs();
      we = 1'b1; w_idx = 5'd7; w_size = 3'd3; w_sel = 4'd0; w_data = 64'h0F0E0D0C0B0A0908;
      r_idx0 = 5'd7; r_idx1 = 5'd7;
      step();
      chk("clr_fwd7", r_data0, 64'h0F0E0D0C0B0A0908);
      model_on = 0;
      idle_inputs();
      clr_req = 1'b1;
      step();
      chk1("clr_ready_drop", ready, 1'b0);
      chk("clr_data_gated", r_data0, 64'd0);
      for (int c = 0; c < 5; c++) begin
         clr_req = 1'b1; we = 1'b1; w_idx = 5'd2; w_size = 3'd0; w_sel = 4'd0;
         rsv = 1'b1; rsv_idx = 5'd7;
         step();
         chk1("clear_werr", w_err, 1'b1);
         chk1("clear_rsv_ignored", r_busy1, 1'b0);
         chk1("clear_ready", ready, 1'b0);
      end
      idle_inputs();
      count_to_ready(n);
      chk("clr_sweep_len", 64'(n + 5), 64'd32);
      chk1("clr_err_after", w_err, 1'b0);
      check_all_zero("clr");

      // asynchronous reset from IDLE with a busy bit and a w_err pulse outstanding
      rsv = 1'b1; rsv_idx = 5'd4; r_idx0 = 5'd4;
      step();
      idle_inputs();
      we = 1'b1; w_idx = 5'd4; w_size = 3'd3; w_sel = 4'd1;
      step();
      idle_inputs();
      chk1("pre_rst_busy", r_busy0, 1'b1);
      chk1("pre_rst_err", w_err, 1'b1);
      chk1("pre_rst_ready", ready, 1'b1);
      sys_rst_n = 1'b0;
      #1;
      chk1("async_ready", ready, 1'b0);
      chk1("async_busy", r_busy0, 1'b0);
      chk1("async_err", w_err, 1'b0);
      #2 sys_rst_n = 1'b1;
      count_to_ready(n);
      chk("rst2_sweep_len", 64'(n), 64'd32);

      // reset in the middle of a clear sweep restarts it from zero
      rsv = 1'b1; rsv_idx = 5'd6; r_idx0 = 5'd6;
      step();
      idle_inputs();
      clr_req = 1'b1;
      step();
      idle_inputs();
      for (int c = 0; c < 10; c++) step();
      chk1("mid_ready", ready, 1'b0);
      sys_rst_n = 1'b0;
      #1;
      chk1("mid_rst_ready", ready, 1'b0);
      chk1("mid_rst_busy", r_busy0, 1'b0);
      #2 sys_rst_n = 1'b1;
      count_to_ready(n);
      chk("mid_sweep_len", 64'(n), 64'd32);
      check_all_zero("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
